// File: rtl/alu_cpu_core_if.sv
// Output bundle of the ALU sequencer: per-instruction fields plus the
// next_out / data_out handshake with the serialising consumer.
interface alu_cpu_core_if;
    logic       next_out;
    logic       data_out;
    logic [7:0] opcode;
    logic [7:0] operand_A_out;
    logic [7:0] operand_B_out;
    logic [7:0] result_out_cpu;
    logic       carry_out_cpu;
    logic       borrow_out_cpu;
    logic       result_ready;
    logic [7:0] pc_out;

    modport master (
        input  next_out,
        output data_out, opcode, operand_A_out, operand_B_out,
               result_out_cpu, carry_out_cpu, borrow_out_cpu,
               result_ready, pc_out
    );

    modport slave (
        output next_out,
        input  data_out, opcode, operand_A_out, operand_B_out,
               result_out_cpu, carry_out_cpu, borrow_out_cpu,
               result_ready, pc_out
    );
endinterface

// File: rtl/alu_cpu_core.sv
// Minimal 8-bit ALU sequencer: fetches {opcode, A, B} from a fixed ROM,
// executes it, and holds the fields on the bus until the consumer asks for more.
module alu_cpu_core (
    input  logic           clk,
    input  logic           rst,
    alu_cpu_core_if.master bus
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT, S_HALT} state_t;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_SHL  = 8'h06;
    localparam logic [7:0] OP_SHR  = 8'h07;
    localparam logic [7:0] OP_NOT  = 8'h08;
    localparam logic [7:0] OP_HALT = 8'hFF;

    state_t      state;
    state_t      next_state;
    logic [7:0]  pc;
    logic [23:0] rom_word;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic        alu_borrow;
    logic [8:0]  add_sum;

    // Program ROM; unlisted addresses behave as HALT.
    always_comb begin
        rom_word = {OP_HALT, 8'h00, 8'h00};
        case (pc)
            8'd0: rom_word = 24'h01_64_1B;
            8'd1: rom_word = 24'h01_C8_64;
            8'd2: rom_word = 24'h02_05_09;
            8'd3: rom_word = 24'h03_F0_3C;
            8'd4: rom_word = 24'h04_F0_0F;
            8'd5: rom_word = 24'h05_AA_FF;
            8'd6: rom_word = 24'h06_81_00;
            default: rom_word = {OP_HALT, 8'h00, 8'h00};
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: next_state = (rom_word[23:16] == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:  next_state = S_OUT;
            S_OUT:   next_state = bus.next_out ? S_FETCH : S_OUT;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= 8'h00;
        end else begin
            state <= next_state;
            if (state == S_OUT && bus.next_out)
                pc <= pc + 8'h01;
        end
    end

    // ALU operates on the latched operands so EXEC sees stable inputs.
    always_comb begin
        alu_res    = 8'h00;
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        add_sum    = {1'b0, bus.operand_A_out} + {1'b0, bus.operand_B_out};
        case (bus.opcode)
            OP_ADD: {alu_carry, alu_res} = add_sum;
            OP_SUB: begin
                alu_res    = bus.operand_A_out - bus.operand_B_out;
                alu_borrow = bus.operand_A_out < bus.operand_B_out;
            end
            OP_AND: alu_res = bus.operand_A_out & bus.operand_B_out;
            OP_OR:  alu_res = bus.operand_A_out | bus.operand_B_out;
            OP_XOR: alu_res = bus.operand_A_out ^ bus.operand_B_out;
            OP_SHL: begin
                alu_carry = bus.operand_A_out[7];
                alu_res   = {bus.operand_A_out[6:0], 1'b0};
            end
            OP_SHR: begin
                alu_carry = bus.operand_A_out[0];
                alu_res   = {1'b0, bus.operand_A_out[7:1]};
            end
            OP_NOT: alu_res = ~bus.operand_A_out;
            default: alu_res = 8'h00;
        endcase
    end

    // Output registers only move on FETCH/EXEC edges, so they stay frozen through S_OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.opcode         <= 8'h00;
            bus.operand_A_out  <= 8'h00;
            bus.operand_B_out  <= 8'h00;
            bus.pc_out         <= 8'h00;
            bus.result_out_cpu <= 8'h00;
            bus.carry_out_cpu  <= 1'b0;
            bus.borrow_out_cpu <= 1'b0;
            bus.data_out       <= 1'b0;
            bus.result_ready   <= 1'b0;
        end else begin
            bus.data_out     <= (next_state == S_OUT);
            bus.result_ready <= (next_state == S_OUT);
            if (state == S_FETCH) begin
                bus.opcode        <= rom_word[23:16];
                bus.operand_A_out <= rom_word[15:8];
                bus.operand_B_out <= rom_word[7:0];
                bus.pc_out        <= pc;
            end
            if (state == S_EXEC) begin
                bus.result_out_cpu <= alu_res;
                bus.carry_out_cpu  <= alu_carry;
                bus.borrow_out_cpu <= alu_borrow;
            end
        end
    end

endmodule

// File: tb/tb_alu_cpu_core.sv
// Self-checking bench for alu_cpu_core: directed program walk plus random
// next_out/reset traffic, compared against an instruction-level reference model.
module tb_alu_cpu_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_cpu_core_if bus ();

    alu_cpu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: which instruction is current and how many edges remain until it shows.
    int m_pc    = 0;
    int m_wait  = 2;
    bit m_halt  = 1'b0;
    bit m_fresh = 1'b1;

    function automatic logic [23:0] ref_rom(input int addr);
        case (addr)
            0: return 24'h01641B;
            1: return 24'h01C864;
            2: return 24'h020509;
            3: return 24'h03F03C;
            4: return 24'h04F00F;
            5: return 24'h05AAFF;
            6: return 24'h068100;
            default: return 24'hFF0000;
        endcase
    endfunction

    function automatic logic [9:0] ref_alu(input int op, input int a, input int b);
        int res;
        int c;
        int bw;
        res = 0; c = 0; bw = 0;
        case (op)
            1: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            2: begin res = (a - b + 256) % 256; bw = (a < b) ? 1 : 0; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            7: begin res = a / 2; c = a % 2; end
            8: res = 255 - a;
            default: res = 0;
        endcase
        return {res[7:0], c[0], bw[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (pc %0d, t=%0t)", tag, got, exp, m_pc, $time);
        end
    endtask

    task automatic checkCycle();
        logic [23:0] w;
        logic [9:0]  r;
        bit          exp_dv;
        exp_dv = !m_fresh && !m_halt && (m_wait == 0);
        w = ref_rom(m_pc);
        r = ref_alu(int'(w[23:16]), int'(w[15:8]), int'(w[7:0]));
        checkOutput("data_out", {31'b0, bus.data_out}, {31'b0, exp_dv});
        checkOutput("result_ready", {31'b0, bus.result_ready}, {31'b0, exp_dv});
        if (m_fresh) begin
            checkOutput("reset_fields",
                {bus.opcode, bus.operand_A_out, bus.operand_B_out, bus.pc_out}, 32'h0);
            checkOutput("reset_result",
                {22'b0, bus.result_out_cpu, bus.carry_out_cpu, bus.borrow_out_cpu}, 32'h0);
        end else if (m_halt) begin
            checkOutput("halt_fields",
                {bus.opcode, bus.operand_A_out, bus.operand_B_out, bus.pc_out},
                {8'hFF, 16'h0000, 8'(m_pc)});
        end else if (m_wait <= 1) begin
            checkOutput("fields",
                {bus.opcode, bus.operand_A_out, bus.operand_B_out, bus.pc_out},
                {w, 8'(m_pc)});
            if (m_wait == 0)
                checkOutput("result",
                    {22'b0, bus.result_out_cpu, bus.carry_out_cpu, bus.borrow_out_cpu},
                    {22'b0, r});
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check at the falling edge.
    task automatic applyStimulus(input bit rst_v, input bit next_v);
        rst          = rst_v;
        bus.next_out = next_v;
        @(posedge clk);
        if (rst_v) begin
            m_pc = 0; m_wait = 2; m_halt = 1'b0; m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
            if (!m_halt) begin
                if (m_wait == 2) begin
                    if (ref_rom(m_pc)[23:16] == 8'hFF) m_halt = 1'b1;
                    m_wait = 1;
                end else if (m_wait == 1) begin
                    m_wait = 0;
                end else if (next_v) begin
                    m_pc   = (m_pc + 1) % 256;
                    m_wait = 2;
                end
            end
        end
        @(negedge clk);
        checkCycle();
    endtask

    initial begin
        bus.next_out = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        // Free-running program to HALT, then confirm HALT absorbs.
        for (int i = 0; i < 40 && !m_halt; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("halted", {31'b0, m_halt}, 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);

        // Back-pressure while pc2 is on the bus.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 20 && !(m_pc == 2 && m_wait == 0); i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

        // Reset while pc4 is executing.
        for (int i = 0; i < 20 && !(m_pc == 4 && m_wait == 1); i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);

        // Random consumer readiness with occasional resets.
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
